// File: rtl/lzc_norm_arbiter_if.sv
// Handshake bundle for lzc_norm_arbiter.
// Request side: per-lane valid/data into the arbiter, one-hot ready back out.
// Result side: registered valid/id/count/empty/normalized operand, with ready
// from downstream.
// Modports:
//   master - the environment (lanes + downstream consumer)
//   slave  - the arbiter itself
interface lzc_norm_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 31
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [IW-1:0]            res_id;
  logic [CW-1:0]            res_cnt;
  logic                     res_empty;
  logic [WIDTH-1:0]         res_norm;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_cnt, res_empty, res_norm
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_cnt, res_empty, res_norm
  );
endinterface

// File: rtl/lzc_norm_arbiter.sv
// Shared leading-zero/one count and left-normalize unit for NUM_REQ lanes.
// A round-robin arbiter picks one valid lane per cycle whenever the output
// register can take a new entry; the selected operand is counted and
// normalized in one pass and registered together with the lane index.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - slave side of lzc_norm_arbiter_if (request and result handshakes)
// MODE = 1 counts leading zeros (fill 0), MODE = 0 counts leading ones (fill 1).
module lzc_norm_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 31,
  parameter bit          MODE    = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lzc_norm_arbiter_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic             res_valid_q;
  logic [IW-1:0]    res_id_q;
  logic [CW-1:0]    res_cnt_q;
  logic             res_empty_q;
  logic [WIDTH-1:0] res_norm_q;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic             slot_free;
  logic             grant_found;
  logic [IW-1:0]    grant_idx;
  logic             accept;

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] match_vec;
  logic [WIDTH-1:0] shifted;
  logic             hit;
  int unsigned      hit_pos;
  logic [CW-1:0]    lead_cnt;
  logic [WIDTH-1:0] norm;

  assign slot_free = !res_valid_q || bus.res_ready;

  // Scan from ptr upward with wrap; the first valid lane wins.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // Gate on rst_i so no lane sees ready while reset is held.
  assign accept = grant_found && slot_free && !rst_i;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  assign ptr_d = IW'((32'(grant_idx) + 1) % NUM_REQ);

  assign operand = bus.req_data[grant_idx*WIDTH +: WIDTH];

  // Leading-ones mode is leading-zeros on the inverted operand; the inverted
  // result of the shift then fills vacated LSBs with ones.
  always_comb begin
    match_vec = MODE ? operand : ~operand;
    hit       = 1'b0;
    hit_pos   = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (match_vec[i]) begin
        hit     = 1'b1;
        hit_pos = i;
      end
    end
    lead_cnt = hit ? CW'(WIDTH - 1 - hit_pos) : '0;
    // With lead_cnt = 0 on empty, norm falls back to the operand unchanged.
    shifted  = match_vec << lead_cnt;
    norm     = MODE ? shifted : ~shifted;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
      res_empty_q <= 1'b0;
      res_norm_q  <= '0;
      ptr_q       <= '0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_id_q    <= grant_idx;
      res_cnt_q   <= lead_cnt;
      res_empty_q <= !hit;
      res_norm_q  <= norm;
      ptr_q       <= ptr_d;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_cnt   = res_cnt_q;
  assign bus.res_empty = res_empty_q;
  assign bus.res_norm  = res_norm_q;
endmodule
